// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        ST_CFG = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int unsigned     W   = 8,
    parameter logic [W-1:0]    MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Run-time programmable serial bit-sequence detector with match pulse and
// saturating match counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned  PAT_W = DEF_PAT_W,
    parameter int unsigned  CNT_W = DEF_CNT_W,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] sr_q;
    logic [PAT_W-1:0] sr_next_c;
    logic [PAT_W-1:0] mask_c;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_clamp_c;
    logic [LEN_W-1:0] fill_q;
    logic             ovl_q;
    logic             shift_c;
    logic             fill_ok_c;
    logic             match_c;
    logic             fill_clr_c;

    // Next-state decode: a zero-length load disarms, any other load (re)arms.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (pat_len != '0) ? ST_RUN : ST_CFG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CFG;
            armed   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed   <= (state_d == ST_RUN);
        end
    end

    assign len_clamp_c = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
        end else if (load) begin
            pat_q <= pattern;
            len_q <= len_clamp_c;
            ovl_q <= overlap_en;
        end
    end

    // A load on the same edge as a valid bit discards that bit.
    assign shift_c   = (state_q == ST_RUN) && x_valid && !load;
    assign sr_next_c = {sr_q[PAT_W-2:0], x};
    assign mask_c    = ~({PAT_W{1'b1}} << len_q);
    assign fill_ok_c = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    assign match_c   = shift_c && fill_ok_c && (((sr_next_c ^ pat_q) & mask_c) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
            z    <= 1'b0;
        end else begin
            z <= match_c;
            if (load) begin
                sr_q <= '0;
            end else if (shift_c) begin
                sr_q <= sr_next_c;
            end
        end
    end

    // Non-overlap mode restarts the fill so the next match needs len fresh bits.
    assign fill_clr_c = load || (match_c && !ovl_q);

    sat_counter #(
        .W   (LEN_W),
        .MAX (LEN_W'(PAT_W))
    ) u_fill_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (shift_c),
        .clr   (fill_clr_c),
        .count (fill_q)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_c),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed testbench for param_seq_detector (PAT_W=4, CNT_W=2).
module tb_param_seq_detector;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic             clk;
    logic             reset;
    logic             x;
    logic             x_valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap_en;
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    int checks;
    int failures;

    param_seq_detector #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .load        (load),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .match_count (match_count),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic ovl, input logic with_bit);
        load       = 1'b1;
        pattern    = p;
        pat_len    = l;
        overlap_en = ovl;
        x_valid    = with_bit;
        x          = 1'b1;
        @(posedge clk);
        #1;
        load    = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic send(input logic b);
        x       = b;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] bits;
        bits  = 4'b1011;
        reset = 1'b1;
        #3;
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", z); end
        checks++;
        if (match_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", match_count); end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            send(bits[i]);
            checks++;
            if (z !== 1'b0) begin failures++; $display("FAIL unarmed_z bit%0d got=%b exp=0", 3 - i, z); end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b1011011;
        exp  = 7'b0001001;
        apply_reset();
        do_load(4'b1011, 3'd4, 1'b1, 1'b0);
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL overlap_armed got=%b exp=1", armed); end
        for (int i = 6; i >= 0; i--) begin
            send(bits[i]);
            checks++;
            if (z !== exp[i]) begin failures++; $display("FAIL overlap_z bit%0d got=%b exp=%b", 7 - i, z, exp[i]); end
        end
        checks++;
        if (match_count !== 2'd2) begin failures++; $display("FAIL overlap_count got=%0d exp=2", match_count); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b1011011;
        exp  = 7'b0001000;
        apply_reset();
        do_load(4'b1011, 3'd4, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            send(bits[i]);
            checks++;
            if (z !== exp[i]) begin failures++; $display("FAIL nonovl_z bit%0d got=%b exp=%b", 7 - i, z, exp[i]); end
        end
        checks++;
        if (match_count !== 2'd1) begin failures++; $display("FAIL nonovl_count got=%0d exp=1", match_count); end
    endtask

    task automatic test_gaps();
        logic [2:0] bits;
        logic [2:0] exp;
        bits = 3'b101;
        exp  = 3'b001;
        apply_reset();
        do_load(4'b0101, 3'd3, 1'b1, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            send(bits[i]);
            checks++;
            if (z !== exp[i]) begin failures++; $display("FAIL gap_z bit%0d got=%b exp=%b", 3 - i, z, exp[i]); end
            for (int g = 0; g < 3; g++) begin
                idle();
                checks++;
                if (z !== 1'b0) begin failures++; $display("FAIL gap_idle_z bit%0d gap%0d got=%b exp=0", 3 - i, g, z); end
            end
        end
        checks++;
        if (match_count !== 2'd1) begin failures++; $display("FAIL gap_count got=%0d exp=1", match_count); end
    endtask

    task automatic test_reconfig();
        logic [5:0] bits;
        logic [5:0] exp;
        logic [3:0] tail;
        apply_reset();
        do_load(4'b1011, 3'd4, 1'b1, 1'b0);
        send(1'b1); send(1'b0); send(1'b1);
        do_load(4'b1011, 3'd4, 1'b1, 1'b0);
        send(1'b1);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL reload_clears_z got=%b exp=0", z); end
        // load with a valid 1: if taken, 0,1,1 would complete 1011 at bit 3
        do_load(4'b1011, 3'd4, 1'b1, 1'b1);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL load_valid_z got=%b exp=0", z); end
        bits = 6'b011011;
        exp  = 6'b000001;
        for (int i = 5; i >= 0; i--) begin
            send(bits[i]);
            checks++;
            if (z !== exp[i]) begin failures++; $display("FAIL load_valid_seq_z bit%0d got=%b exp=%b", 6 - i, z, exp[i]); end
        end
        // pat_len beyond PAT_W clamps to PAT_W
        do_load(4'b1011, 3'd7, 1'b1, 1'b0);
        tail = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            send(tail[i]);
            checks++;
            if (z !== (i == 0)) begin failures++; $display("FAIL clamp_z bit%0d got=%b exp=%b", 4 - i, z, (i == 0)); end
        end
        checks++;
        if (match_count !== 2'd2) begin failures++; $display("FAIL reconfig_count got=%0d exp=2", match_count); end
        do_load(4'b1011, 3'd0, 1'b1, 1'b0);
        checks++;
        if (armed !== 1'b0) begin failures++; $display("FAIL disarm_armed got=%b exp=0", armed); end
        for (int i = 3; i >= 0; i--) begin
            send(tail[i]);
            checks++;
            if (z !== 1'b0) begin failures++; $display("FAIL disarm_z bit%0d got=%b exp=0", 4 - i, z); end
        end
        checks++;
        if (match_count !== 2'd2) begin failures++; $display("FAIL disarm_count got=%0d exp=2", match_count); end
    endtask

    task automatic test_saturation();
        logic [5:0] exp;
        exp = 6'b011111;
        apply_reset();
        do_load(4'b0011, 3'd2, 1'b1, 1'b0);
        for (int i = 5; i >= 0; i--) begin
            send(1'b1);
            checks++;
            if (z !== exp[i]) begin failures++; $display("FAIL sat_z bit%0d got=%b exp=%b", 6 - i, z, exp[i]); end
        end
        checks++;
        if (match_count !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", match_count); end
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        checks++;
        if (z !== 1'b1) begin failures++; $display("FAIL clr_match_z got=%b exp=1", z); end
        checks++;
        if (match_count !== 2'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", match_count); end
        send(1'b1);
        checks++;
        if (match_count !== 2'd1) begin failures++; $display("FAIL post_clr_count got=%0d exp=1", match_count); end
    endtask

    task automatic test_async_reset();
        logic [3:0] bits;
        bits = 4'b1011;
        apply_reset();
        do_load(4'b1011, 3'd4, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) send(bits[i]);
        checks++;
        if (z !== 1'b1) begin failures++; $display("FAIL pre_reset_z got=%b exp=1", z); end
        send(1'b0);
        send(1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL async_z got=%b exp=0", z); end
        checks++;
        if (match_count !== 2'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", match_count); end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("FAIL async_armed got=%b exp=0", armed); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1'b1);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL post_reset_z got=%b exp=0", z); end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("FAIL post_reset_armed got=%b exp=0", armed); end
        do_load(4'b1011, 3'd4, 1'b1, 1'b0);
        send(1'b1);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL rearm_z got=%b exp=0", z); end
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL rearm_armed got=%b exp=1", armed); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        x          = 1'b0;
        x_valid    = 1'b0;
        load       = 1'b0;
        pattern    = '0;
        pat_len    = '0;
        overlap_en = 1'b0;
        cnt_clr    = 1'b0;
        #1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_reconfig();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised, run-time programmable serial bit-sequence detector. Successor to the fixed-pattern seq_detector.
- Pattern, length and overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe.
- Produces a one-cycle match pulse and a saturating match counter. Sits on serial control/protocol links in the lab designs.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2)
- CNT_W, 8, width of match counter
- LEN_W, $clog2(PAT_W+1), derived width of pat_len (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- x  in  1  serial data bit
- x_valid  in  1  x is sampled on this edge only when high
- load  in  1  latch pattern/pat_len/overlap_en into config registers
- pattern  in  PAT_W  target sequence; pattern[len-1] is the first bit received, pattern[0] the last
- pat_len  in  LEN_W  active pattern length
- overlap_en  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- cnt_clr  in  1  synchronous clear of match_count
- z  out  1  registered match pulse, one cycle wide
- match_count  out  CNT_W  saturating number of matches since reset/cnt_clr
- armed  out  1  high in RUN state (valid configuration loaded)

Behaviour:
- Reset (async, active-high). All state clears immediately: FSM=CFG, shift register=0, fill count=0, config registers=0, z=0, match_count=0, armed=0.
- FSM states:
  - CFG: disarmed. x is ignored.
  - RUN: detecting.
- FSM transitions:
  - CFG -> RUN on load with pat_len != 0.
  - RUN -> CFG on load with pat_len == 0.
  - RUN -> RUN on load with pat_len != 0: reconfigures and clears history.
- pat_len > PAT_W at load is clamped to PAT_W.
- Load effects:
  - Clears shift register and fill count.
  - Forces z=0 on the next cycle.
  - Leaves match_count unchanged.
  - load and x_valid in the same cycle: load wins and that x bit is discarded.
- Shifting (RUN, x_valid=1): shift register shifts left, new x enters bit 0. Fill count increments, saturating at PAT_W.
- Match condition on that edge: (fill count + 1) >= len and low len bits of the next shift value == low len bits of stored pattern.
- Latency: z is set at the same edge that samples the completing bit and is high for exactly one cycle. Back-to-back matches on consecutive valid cycles give z high on consecutive cycles.
- Non-overlap mode (overlap_en=0): on a match, fill count resets to 0, so the next match needs len fresh bits.
- Overlap mode: history is retained after a match.
- x_valid=0: no shift, no count change, z=0.
- match_count increments by 1 per match and saturates at 2^CNT_W-1.
- cnt_clr has priority over increment: a coincident match is not counted, but z still pulses.
- armed is the registered decode of RUN.
- Reset asserted mid-stream aborts any partial match. No z pulse is produced for a bit sampled coincident with reset.

Decomposition:
- Shared package (seq_det_pkg) holds:
  - FSM state encoding (ST_CFG, ST_RUN).
  - Default PAT_W/CNT_W constants.
- One natural sub-module: sat_counter (parametrised width; inc/clr inputs, clr priority, saturating). It is reused for the fill count and match_count.

Test Plan:
- Overlap match: PAT_W=4, load pattern=4'b1011, len=4, overlap_en=1. Feed valid bits 1,0,1,1,0,1,1 -> z pulses after bit 4 and bit 7; match_count=2; armed=1.
- Non-overlap: same load with overlap_en=0 and same stream -> z only after bit 4; match_count=1.
- Short pattern and valid gaps: load pattern=4'b0101, len=3. Stream 1,0,1 with x_valid low for 3 cycles between each bit -> z once after the third valid bit; no z during gap cycles.
- Reconfigure/priority:
  - Load mid-stream after bits 1,0,1, then 1 -> no z (history cleared).
  - load with x_valid=1 on the same edge -> that bit is ignored.
  - load with pat_len=0 -> armed=0; stream 1011 produces no z.
- Saturation and clear: CNT_W=2, pattern 2'b11, len=2, overlap. Feed six 1s -> 5 matches, match_count=3. Then cnt_clr coincident with a match -> count=0 and z=1.
- Async reset: assert reset between clock edges mid-pattern -> outputs zero immediately; after release, the partial pattern does not complete and armed=0 until the next load.
